// File: rtl/sram_bus_arbiter.sv
// Shares one memory port between the instruction-fetch and data-access requesters.
// Data has fixed priority. Each response is held in its requester's rdata register until the pipeline advances.
module sram_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic [DATA_W-1:0]     data_rdata,
  input  logic                  pipe_adv,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              inst_done_q, inst_done_d;
  logic              data_done_q, data_done_d;
  logic              inst_stale_q, inst_stale_d;
  logic              data_stale_q, data_stale_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic inst_pend;
  logic data_pend;

  assign inst_pend = inst_req & ~inst_done_q;
  assign data_pend = data_req & ~data_done_q;
  assign stall     = inst_pend | data_pend | (state_q != IDLE);

  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_done_d  = inst_done_q;
    data_done_d  = data_done_q;
    inst_stale_d = inst_stale_q;
    data_stale_d = data_stale_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    // An advance while a transaction is in flight marks that transaction's response as unwanted.
    if (pipe_adv) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
      if (state_q != IDLE) begin
        if (owner_q == OWN_DATA) data_stale_d = 1'b1;
        else                     inst_stale_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (data_pend) begin
          owner_d     = OWN_DATA;
          mem_req_d   = 1'b1;
          mem_wr_d    = data_wr;
          mem_wstrb_d = data_wstrb;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          state_d     = REQ;
        end else if (inst_pend) begin
          owner_d     = OWN_INST;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_wstrb_d = '0;
          mem_addr_d  = inst_addr;
          mem_wdata_d = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // A same-cycle advance makes the response stale, so pipe_adv is tested here as well as the stale flag.
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_DATA) begin
            if (data_stale_q | pipe_adv) begin
              data_stale_d = 1'b0;
            end else begin
              data_done_d = 1'b1;
              if (!mem_wr_q) data_rdata_d = mem_rdata;
            end
          end else begin
            if (inst_stale_q | pipe_adv) begin
              inst_stale_d = 1'b0;
            end else begin
              inst_done_d  = 1'b1;
              inst_rdata_d = mem_rdata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      inst_stale_q <= 1'b0;
      data_stale_q <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      inst_stale_q <= inst_stale_d;
      data_stale_q <= data_stale_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

endmodule
